// File: rtl/data_array_port_ctrl.sv
// ---------------------------------------------------------------------------
// data_array_port_ctrl
//
// Requester-side controller for a single-port, byte-masked data-array SRAM
// macro with a 1-cycle read latency. After reset it can zero-fill the whole
// array. It then accepts read/write requests and returns read data through a
// 2-entry response queue. The queue passes data straight through when it is
// empty.
//
// Handshake: a transfer happens on a rising clock edge where valid and ready
// are both high. The producer holds its payload stable while valid is high
// and ready is low. req_ready is derived only from registered state, so it
// never depends on req_valid or req_write. resp_rdata is meaningful only
// while resp_valid is high.
//
// Ports:
//   clock, reset_n          single clock (also clocks the macro), sync active-low reset
//   req_valid/req_ready     request handshake
//   req_write               1 = write, 0 = read
//   req_addr                word address
//   req_wdata/req_mask      write data and per-byte write enable (mask unused for reads)
//   resp_valid/resp_ready   read-response handshake
//   resp_rdata              read data, returned in request order
//   init_done               high once the zero-fill is finished (or at once when not filling)
//   ram_en/ram_wmode        macro enable and write-mode select
//   ram_addr/ram_wdata      macro address and write data
//   ram_wmask               macro byte mask
//   ram_rdata               macro read data, valid the cycle after a read enable
// ---------------------------------------------------------------------------
module data_array_port_ctrl #(
    parameter int ADDR_BITS     = 12,
    parameter int DATA_BYTES    = 4,
    parameter int INIT_ON_RESET = 1
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_write,
    input  logic [ADDR_BITS-1:0]    req_addr,
    input  logic [8*DATA_BYTES-1:0] req_wdata,
    input  logic [DATA_BYTES-1:0]   req_mask,
    output logic                    resp_valid,
    input  logic                    resp_ready,
    output logic [8*DATA_BYTES-1:0] resp_rdata,
    output logic                    init_done,
    output logic                    ram_en,
    output logic                    ram_wmode,
    output logic [ADDR_BITS-1:0]    ram_addr,
    output logic [8*DATA_BYTES-1:0] ram_wdata,
    output logic [DATA_BYTES-1:0]   ram_wmask,
    input  logic [8*DATA_BYTES-1:0] ram_rdata
);

    localparam int DW = 8 * DATA_BYTES;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t                 state;
    logic [ADDR_BITS-1:0]   init_cnt;
    logic                   inflight;   // a read was issued last cycle
    logic [1:0]             occ;        // response-queue occupancy, 0..2
    logic                   head;       // index of the oldest queued entry
    logic [DW-1:0]          q_mem [2];

    logic [1:0]             credit_used;
    logic                   fire;
    logic                   rd_fire;
    logic                   q_pop;
    logic                   q_push;
    logic                   tail;

    // Every read that is queued or in flight holds one of the two queue
    // slots. This guarantees that the queue can never overflow.
    assign credit_used = occ + {1'b0, inflight};
    assign req_ready   = reset_n && (state == ST_RUN) && (credit_used < 2'd2);
    assign init_done   = reset_n && (state == ST_RUN);

    assign fire    = req_valid && req_ready;
    assign rd_fire = fire && !req_write;

    // Flow-through: with an empty queue, returning read data goes straight
    // to the output. It is stored only if the consumer does not take it.
    assign resp_valid = (occ != 2'd0) || inflight;
    assign resp_rdata = (occ != 2'd0) ? q_mem[head] : ram_rdata;

    assign q_pop  = resp_ready && (occ != 2'd0);
    assign q_push = inflight && !((occ == 2'd0) && resp_ready);
    // With occ 0 the tail is the head slot. With occ 1 it is the other slot.
    assign tail   = head ^ occ[0];

    // Macro port drive. The port is forced idle while reset is held.
    always_comb begin
        ram_en    = 1'b0;
        ram_wmode = 1'b0;
        ram_addr  = '0;
        ram_wdata = '0;
        ram_wmask = '0;
        if (reset_n) begin
            if (state == ST_INIT) begin
                ram_en    = 1'b1;
                ram_wmode = 1'b1;
                ram_addr  = init_cnt;
                ram_wdata = '0;
                ram_wmask = '1;
            end else if (fire) begin
                ram_en    = 1'b1;
                ram_wmode = req_write;
                ram_addr  = req_addr;
                ram_wdata = req_wdata;
                ram_wmask = req_write ? req_mask : '0;
            end
        end
    end

    // Control state: FSM, init counter, read tracking, queue pointers.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state    <= (INIT_ON_RESET != 0) ? ST_INIT : ST_RUN;
            init_cnt <= '0;
            inflight <= 1'b0;
            occ      <= 2'd0;
            head     <= 1'b0;
        end else begin
            inflight <= rd_fire;
            case (state)
                ST_INIT: begin
                    init_cnt <= init_cnt + 1'b1;
                    if (init_cnt == '1) begin
                        state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    state <= ST_RUN;
                end
                default: begin
                    state <= ST_RUN;
                end
            endcase
            if (q_pop) begin
                head <= ~head;
            end
            occ <= occ + {1'b0, q_push} - {1'b0, q_pop};
        end
    end

    // Queue storage. It needs no reset because occ qualifies every entry.
    always_ff @(posedge clock) begin
        if (reset_n && q_push) begin
            q_mem[tail] <= ram_rdata;
        end
    end

endmodule

// File: tb/tb_data_array_port_ctrl.sv
// ---------------------------------------------------------------------------
// Testbench for data_array_port_ctrl.
// A behavioural SRAM sits behind the main instance, which zero-fills on
// reset. A second instance without zero-fill checks that it is ready at once.
// Stimulus is driven just after the rising edge. Outputs are sampled on the
// falling edge.
// ---------------------------------------------------------------------------
module tb_data_array_port_ctrl;

    localparam int AB    = 12;
    localparam int DB    = 4;
    localparam int DW    = 32;
    localparam int DEPTH = 4096;

    // ---------------- clock / reset ----------------
    logic clock   = 1'b0;
    logic reset_n = 1'b0;
    int   cyc     = 0;

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- main DUT (zero-fill on reset) ----------------
    logic          req_valid = 1'b0, req_write = 1'b0;
    logic [AB-1:0] req_addr  = '0;
    logic [DW-1:0] req_wdata = '0;
    logic [DB-1:0] req_mask  = '0;
    logic          resp_ready = 1'b1;
    logic          req_ready, resp_valid, init_done;
    logic [DW-1:0] resp_rdata;
    logic          ram_en, ram_wmode;
    logic [AB-1:0] ram_addr;
    logic [DW-1:0] ram_wdata;
    logic [DB-1:0] ram_wmask;
    logic [DW-1:0] ram_rdata = '0;

    data_array_port_ctrl #(.ADDR_BITS(AB), .DATA_BYTES(DB), .INIT_ON_RESET(1)) u_dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_mask   (req_mask),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_rdata (resp_rdata),
        .init_done  (init_done),
        .ram_en     (ram_en),
        .ram_wmode  (ram_wmode),
        .ram_addr   (ram_addr),
        .ram_wdata  (ram_wdata),
        .ram_wmask  (ram_wmask),
        .ram_rdata  (ram_rdata)
    );

    // ---------------- second DUT (no zero-fill) ----------------
    logic          z_req_ready, z_resp_valid, z_init_done;
    logic [DW-1:0] z_resp_rdata;
    logic          z_ram_en, z_ram_wmode;
    logic [AB-1:0] z_ram_addr;
    logic [DW-1:0] z_ram_wdata;
    logic [DB-1:0] z_ram_wmask;

    data_array_port_ctrl #(.ADDR_BITS(AB), .DATA_BYTES(DB), .INIT_ON_RESET(0)) u_dut_z (
        .clock      (clock),
        .reset_n    (reset_n),
        .req_valid  (1'b0),
        .req_ready  (z_req_ready),
        .req_write  (1'b0),
        .req_addr   ({AB{1'b0}}),
        .req_wdata  ({DW{1'b0}}),
        .req_mask   ({DB{1'b0}}),
        .resp_valid (z_resp_valid),
        .resp_ready (1'b1),
        .resp_rdata (z_resp_rdata),
        .init_done  (z_init_done),
        .ram_en     (z_ram_en),
        .ram_wmode  (z_ram_wmode),
        .ram_addr   (z_ram_addr),
        .ram_wdata  (z_ram_wdata),
        .ram_wmask  (z_ram_wmask),
        .ram_rdata  ({DW{1'b0}})
    );

    // ---------------- behavioural SRAM macro ----------------
    logic [DW-1:0] mem [DEPTH];

    initial begin
        // Non-zero contents, so the zero-fill has a visible effect.
        for (int i = 0; i < DEPTH; i++) mem[i] = 32'hA5A5_0000 | i;
    end

    always @(posedge clock) begin
        if (ram_en) begin
            if (ram_wmode) begin
                for (int b = 0; b < DB; b++) begin
                    if (ram_wmask[b]) mem[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
                end
            end else begin
                ram_rdata <= mem[ram_addr];
            end
        end
    end

    // ---------------- scoreboard ----------------
    logic [DW-1:0] exp_q[$];
    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: credit cross-check, then pop and compare on every response.
    // The count of outstanding reads equals the number of fired reads that
    // have not yet been consumed.
    always @(negedge clock) begin
        if (reset_n && init_done) begin
            if (exp_q.size() > 2) begin
                n_checks++;
                n_errors++;
                $display("FAIL overflow: %0d reads outstanding, limit 2", exp_q.size());
            end
            check("credit_ready", {31'b0, req_ready}, {31'b0, (exp_q.size() < 2)});
        end
        if (reset_n && resp_valid && resp_ready) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_resp: got %h, expected no response", resp_rdata);
            end else begin
                check("resp_rdata", resp_rdata, exp_q.pop_front());
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic idle();
        req_valid = 1'b0;
        req_write = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        req_mask  = '0;
    endtask

    // Present one request and hold it until it fires. On return the time is
    // just after the firing edge, so another issue follows back to back.
    task automatic issue(input logic w, input logic [AB-1:0] a, input logic [DW-1:0] d,
                         input logic [DB-1:0] m, input logic [DW-1:0] exp);
        bit fired;
        fired = 1'b0;
        req_valid = 1'b1;
        req_write = w;
        req_addr  = a;
        req_wdata = d;
        req_mask  = m;
        for (int c = 0; c < 50 && !fired; c++) begin
            @(negedge clock);
            if (req_ready) begin
                fired = 1'b1;
                check("ram_ctrl", {14'b0, ram_en, ram_wmode, ram_wmask, ram_addr},
                      {14'b0, 1'b1, w, (w ? m : 4'h0), a});
                check("ram_wdata", ram_wdata, d);
            end
            @(posedge clock);
            if (fired && !w) exp_q.push_back(exp);
            #1;
        end
        if (!fired) begin
            n_checks++;
            n_errors++;
            $display("FAIL issue_timeout: addr %h not accepted within 50 cycles", a);
        end
    endtask

    // Check n init cycles. The first one checked must be the cycle right
    // after reset release.
    task automatic check_init(input int n, input bit with_z);
        for (int k = 0; k < n; k++) begin
            @(negedge clock);
            if (k == 0 && with_z) begin
                check("noinit_first_cycle", {29'b0, z_init_done, z_req_ready, z_ram_en}, {29'b0, 3'b110});
            end
            check("init_port", {12'b0, ram_en, ram_wmode, ram_wmask, req_ready, init_done, ram_addr},
                  {12'b0, 1'b1, 1'b1, 4'hF, 1'b0, 1'b0, 12'(k)});
            check("init_wdata", ram_wdata, 32'h0);
        end
    endtask

    task automatic reset_cycles(input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clock);
            check("ram_en_in_reset", {31'b0, ram_en}, 32'h0);
            check("ready_done_in_reset", {30'b0, req_ready, init_done}, 32'h0);
        end
        @(posedge clock);
        #1;
    endtask

    // ---------------- main sequence ----------------
    initial begin
        idle();
        resp_ready = 1'b1;
        reset_n = 1'b0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        check("reset_state", {27'b0, req_ready, resp_valid, init_done, z_req_ready, z_init_done}, 32'h0);
        @(posedge clock);
        #1;
        reset_n = 1'b1;

        // Full zero-fill: addresses 0..4095 on consecutive cycles.
        check_init(DEPTH, 1'b1);
        @(negedge clock);
        check("init_done_rise", {29'b0, init_done, req_ready, ram_en}, {29'b0, 3'b110});
        @(posedge clock);
        #1;

        // Masked write and read-back. Only lanes 0 and 2 are written over the zeros.
        issue(1'b1, 12'h0A5, 32'hDEADBEEF, 4'b0101, 32'h0);
        issue(1'b0, 12'h0A5, 32'h0, 4'h0, 32'h00AD00EF);
        idle();
        @(negedge clock);
        check("read_latency", {31'b0, resp_valid}, 32'h1);
        @(posedge clock);
        #1;
        // A write with an all-zero mask still enables the macro and changes nothing.
        issue(1'b1, 12'h0A5, 32'hFFFFFFFF, 4'b0000, 32'h0);
        issue(1'b0, 12'h0A5, 32'h0, 4'h0, 32'h00AD00EF);
        idle();
        @(negedge clock);
        check("idle_ram_en", {31'b0, ram_en}, 32'h0);
        @(posedge clock);
        #1;

        // Backpressure: two reads are accepted, then ready drops until the consumer drains.
        issue(1'b1, 12'h200, 32'h11111111, 4'hF, 32'h0);
        issue(1'b1, 12'h201, 32'h22222222, 4'hF, 32'h0);
        issue(1'b1, 12'h202, 32'h33333333, 4'hF, 32'h0);
        idle();
        resp_ready = 1'b0;
        issue(1'b0, 12'h200, 32'h0, 4'h0, 32'h11111111);
        issue(1'b0, 12'h201, 32'h0, 4'h0, 32'h22222222);
        req_valid = 1'b1;
        req_write = 1'b0;
        req_addr  = 12'h202;
        @(negedge clock);
        check("ready_drop", {31'b0, req_ready}, 32'h0);
        check("held_head", resp_rdata, 32'h11111111);
        @(posedge clock);
        #1;
        @(negedge clock);
        check("ready_full", {30'b0, req_ready, resp_valid}, 32'h1);
        @(posedge clock);
        #1;
        resp_ready = 1'b1;
        issue(1'b0, 12'h202, 32'h0, 4'h0, 32'h33333333);
        idle();
        repeat (3) @(posedge clock);
        #1;
        check("drain_empty", exp_q.size(), 32'h0);

        // Streaming: 100 reads, one per cycle, and the response stream has no gaps.
        for (int i = 0; i < 100; i++) begin
            issue(1'b1, 12'(12'h300 + i), 32'hC0DE0000 | (12'h300 + i), 4'hF, 32'h0);
        end
        begin
            int t0;
            t0 = cyc;
            for (int i = 0; i < 100; i++) begin
                issue(1'b0, 12'(12'h300 + i), 32'h0, 4'h0, 32'hC0DE0000 | (12'h300 + i));
                check("stream_no_gap", exp_q.size(), 32'h1);
            end
            check("stream_cycles", cyc - t0, 32'd100);
        end
        idle();
        @(posedge clock);
        #1;
        check("stream_drained", exp_q.size(), 32'h0);

        // Reset while the queue and the pipeline hold reads: both are discarded.
        resp_ready = 1'b0;
        issue(1'b0, 12'h200, 32'h0, 4'h0, 32'h11111111);
        issue(1'b0, 12'h201, 32'h0, 4'h0, 32'h22222222);
        idle();
        reset_n = 1'b0;
        exp_q.delete();
        reset_cycles(3);
        @(negedge clock);
        check("flushed_resp_valid", {31'b0, resp_valid}, 32'h0);
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        resp_ready = 1'b1;

        // Reset asserted at init counter 1000. Init restarts at address 0.
        check_init(1001, 1'b0);
        @(posedge clock);
        #1;
        reset_n = 1'b0;
        reset_cycles(3);
        reset_n = 1'b1;
        check_init(DEPTH, 1'b0);
        @(negedge clock);
        check("reinit_done", {30'b0, init_done, req_ready}, 32'h3);
        @(posedge clock);
        #1;

        // The zero-fill cleared earlier data. The array still works after re-init.
        issue(1'b0, 12'h201, 32'h0, 4'h0, 32'h0);
        issue(1'b1, 12'h0A5, 32'h12345678, 4'hF, 32'h0);
        issue(1'b0, 12'h0A5, 32'h0, 4'h0, 32'h12345678);
        idle();

        for (int c = 0; c < 20 && exp_q.size() != 0; c++) @(posedge clock);
        check("final_queue_empty", exp_q.size(), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
